rpn_calc_core: RTL and testbench

//  Parametrised successor of the calculator operand-buffer/ALU datapath. Accepts decimal digit entry.

---
 rtl/rpn_calc_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_rpn_calc_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_calc_core.sv
// rpn_calc_core: RPN calculator core with decimal entry, operand stack and ALU.
// Define RPN_CALC_MUL_EN to enable the iterative shift-add multiply (opcode 6).
module rpn_calc_core #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       hwclk,
    input  logic                       reset,
    input  logic                       digit_vld,
    input  logic [3:0]                 digit,
    input  logic                       enter,
    input  logic                       op_vld,
    input  logic [2:0]                 opcode,
    input  logic                       clear,
    output logic                       busy,
    output logic                       result_ready,
    output logic [WIDTH-1:0]           disp,
    output logic                       sign,
    output logic                       ovf,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_DROP = 3'd7;

`ifdef RPN_CALC_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MUL = 3'd6;
    typedef enum logic [2:0] {IDLE, ENTRY, PUSH, EXEC, MUL} state_t;
`else
    typedef enum logic [2:0] {IDLE, ENTRY, PUSH, EXEC} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stk [DEPTH];
    logic [DW-1:0]    dep_q;
    logic [WIDTH-1:0] entry_q;
    logic [2:0]       op_q;

    logic             act_clr, act_op, act_enter, act_digit;
    logic [IW-1:0]    i0, i1, i2;
    logic [WIDTH-1:0] top, nxt, dval;
    logic [WIDTH+3:0] ent_nxt;
    logic             ent_ovf;
    logic             do_push, full;
    logic [WIDTH-1:0] push_val;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ovf, alu_bin, alu_ill, alu_ok;

`ifdef RPN_CALC_MUL_EN
    assign busy = (state_q == PUSH) || (state_q == EXEC) || (state_q == MUL);
`else
    assign busy = (state_q == PUSH) || (state_q == EXEC);
`endif

    always_comb begin
        act_clr   = 1'b0;
        act_op    = 1'b0;
        act_enter = 1'b0;
        act_digit = 1'b0;
        priority case (1'b1)
            clear:     act_clr   = 1'b1;
            busy:      ;
            op_vld:    act_op    = 1'b1;
            enter:     act_enter = 1'b1;
            digit_vld: act_digit = (digit <= 4'd9);
            default:   ;
        endcase
    end

    assign i0  = IW'(dep_q);
    assign i1  = IW'(dep_q - DW'(1));
    assign i2  = IW'(dep_q - DW'(2));
    assign top = (dep_q != '0) ? stk[i1] : '0;
    assign nxt = (dep_q > DW'(1)) ? stk[i2] : '0;
    assign full = (dep_q == DW'(DEPTH));

    assign ent_nxt = {4'd0, entry_q} * (WIDTH+4)'(10) + (WIDTH+4)'(digit);
    assign ent_ovf = ent_nxt > {4'd0, SMAX};

    assign do_push  = act_enter || (state_q == PUSH);
    assign push_val = (state_q == IDLE) ? top : entry_q;

    always_comb begin
        alu_r   = '0;
        alu_ovf = 1'b0;
        alu_bin = 1'b1;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_r   = nxt + top;
                alu_ovf = (nxt[WIDTH-1] == top[WIDTH-1]) &&
                          (alu_r[WIDTH-1] != nxt[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r   = nxt - top;
                alu_ovf = (nxt[WIDTH-1] != top[WIDTH-1]) &&
                          (alu_r[WIDTH-1] != nxt[WIDTH-1]);
            end
            OP_AND: alu_r = nxt & top;
            OP_OR:  alu_r = nxt | top;
            OP_XOR: alu_r = nxt ^ top;
            OP_NEG: begin
                alu_bin = 1'b0;
                alu_r   = -top;
                alu_ovf = (top == SMIN);
            end
            OP_DROP: alu_bin = 1'b0;
            default: alu_ill = 1'b1;
        endcase
        alu_ok = !alu_ill &&
                 (alu_bin ? (dep_q >= DW'(2)) : (dep_q != '0));
    end

`ifdef RPN_CALC_MUL_EN
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_nxt, prod_s;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 mul_ovf, mul_last, mul_short;

    // Sign-magnitude shift-add; operands stay on the stack while iterating.
    assign mag_a     = nxt[WIDTH-1] ? -nxt : nxt;
    assign mag_b     = top[WIDTH-1] ? -top : top;
    assign acc_nxt   = acc_q + (mag_b[cnt_q] ?
                       ({{WIDTH{1'b0}}, mag_a} << cnt_q) : '0);
    assign prod_s    = (nxt[WIDTH-1] ^ top[WIDTH-1]) ? -acc_nxt : acc_nxt;
    assign mul_ovf   = !((&prod_s[2*WIDTH-1:WIDTH-1]) ||
                         !(|prod_s[2*WIDTH-1:WIDTH-1]));
    assign mul_last  = (cnt_q == CW'(WIDTH-1));
    assign mul_short = (cnt_q == '0) && (dep_q < DW'(2));

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (act_clr || state_q != MUL) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= acc_nxt;
        end
    end
`endif

    function automatic state_t dispatch(input logic [2:0] op);
`ifdef RPN_CALC_MUL_EN
        return (op == OP_MUL) ? MUL : EXEC;
`else
        return (op == 3'd6) ? EXEC : EXEC;
`endif
    endfunction

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (act_op)         state_d = dispatch(opcode);
                else if (act_digit) state_d = ENTRY;
            end
            ENTRY: begin
                if (act_op)         state_d = PUSH;
                else if (act_enter) state_d = IDLE;
            end
            PUSH: state_d = dispatch(op_q);
            EXEC: state_d = IDLE;
`ifdef RPN_CALC_MUL_EN
            MUL: if (mul_short || mul_last) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        if (act_clr) state_d = IDLE;
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            dep_q        <= '0;
            entry_q      <= '0;
            op_q         <= '0;
            ovf          <= 1'b0;
            err          <= 1'b0;
            result_ready <= 1'b0;
        end else if (act_clr) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            dep_q        <= '0;
            entry_q      <= '0;
            ovf          <= 1'b0;
            err          <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            result_ready <= 1'b0;
            if (act_op) op_q <= opcode;
            if (act_digit) begin
                if (ent_ovf) ovf     <= 1'b1;
                else         entry_q <= ent_nxt[WIDTH-1:0];
            end
            if (do_push) begin
                if (full) begin
                    err <= 1'b1;
                end else begin
                    stk[i0] <= push_val;
                    dep_q   <= dep_q + DW'(1);
                end
                if (state_q != IDLE) entry_q <= '0;
            end
            if (state_q == EXEC) begin
                if (!alu_ok) begin
                    err <= 1'b1;
                end else begin
                    result_ready <= 1'b1;
                    ovf          <= ovf | alu_ovf;
                    if (alu_bin) begin
                        stk[i2] <= alu_r;
                        dep_q   <= dep_q - DW'(1);
                    end else if (op_q == OP_DROP) begin
                        dep_q   <= dep_q - DW'(1);
                    end else begin
                        stk[i1] <= alu_r;
                    end
                end
            end
`ifdef RPN_CALC_MUL_EN
            if (state_q == MUL) begin
                if (mul_short) begin
                    err <= 1'b1;
                end else if (mul_last) begin
                    result_ready <= 1'b1;
                    ovf          <= ovf | mul_ovf;
                    stk[i2]      <= prod_s[WIDTH-1:0];
                    dep_q        <= dep_q - DW'(1);
                end
            end
`endif
        end
    end

    always_comb begin
        dval  = (state_q == ENTRY) ? entry_q : top;
        sign  = dval[WIDTH-1];
        disp  = sign ? -dval : dval;
        depth = dep_q;
    end
endmodule

// File: tb/tb_rpn_calc_core.sv
// tb_rpn_calc_core: directed checks of entry, stack ops, flags and clear.
// Exercises the multiply path when RPN_CALC_MUL_EN is defined.
module tb_rpn_calc_core;
    logic       hwclk = 1'b0;
    logic       reset;
    logic       digit_vld;
    logic [3:0] digit;
    logic       enter;
    logic       op_vld;
    logic [2:0] opcode;
    logic       clear;
    logic       busy;
    logic       result_ready;
    logic [8:0] disp;
    logic       sign;
    logic       ovf;
    logic       err;
    logic [2:0] depth;

    int tests = 0;
    int fails = 0;
    int n;

    rpn_calc_core #(.WIDTH(9), .DEPTH(4)) dut (
        .hwclk(hwclk), .reset(reset),
        .digit_vld(digit_vld), .digit(digit),
        .enter(enter), .op_vld(op_vld), .opcode(opcode),
        .clear(clear), .busy(busy), .result_ready(result_ready),
        .disp(disp), .sign(sign), .ovf(ovf), .err(err),
        .depth(depth)
    );

    always #5 hwclk = ~hwclk;

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic key(input int d);
        digit_vld = 1'b1;
        digit = 4'(d);
        tick();
        digit_vld = 1'b0;
    endtask

    task automatic ent();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push_num(input int v);
        if (v >= 100) key(v / 100);
        if (v >= 10) key((v / 10) % 10);
        key(v % 10);
        ent();
    endtask

    // Op issued from IDLE: one cycle in EXEC, then the result is visible.
    task automatic op_idle(input int o);
        op_vld = 1'b1;
        opcode = 3'(o);
        tick();
        op_vld = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        digit_vld = 1'b0;
        digit = 4'd0;
        enter = 1'b0;
        op_vld = 1'b0;
        opcode = 3'd0;
        clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_rr", result_ready, 0);
        chk("rst_disp", disp, 0);
        chk("rst_sign", sign, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        chk("rst_depth", depth, 0);

        key(1);
        key(2);
        chk("entry_disp", disp, 12);
        key(3);
        ent();
        chk("t1_depth", depth, 1);
        chk("t1_disp", disp, 123);
        chk("t1_sign", sign, 0);
        chk("t1_ovf", ovf, 0);

        clr();
        push_num(5);
        push_num(12);
        op_vld = 1'b1;
        opcode = 3'd1;
        tick();
        op_vld = 1'b0;
        chk("sub_busy", busy, 1);
        chk("sub_rr0", result_ready, 0);
        digit_vld = 1'b1;
        digit = 4'd9;
        tick();
        digit_vld = 1'b0;
        chk("sub_rr", result_ready, 1);
        chk("sub_disp", disp, 7);
        chk("sub_sign", sign, 1);
        chk("sub_depth", depth, 1);
        tick();
        chk("sub_rr_pulse", result_ready, 0);
        chk("busy_ignored", disp, 7);

        clr();
        push_num(5);
        key(1);
        key(2);
        op_vld = 1'b1;
        opcode = 3'd1;
        tick();
        op_vld = 1'b0;
        chk("push_busy", busy, 1);
        tick();
        chk("push_rr0", result_ready, 0);
        tick();
        chk("entry_op_rr", result_ready, 1);
        chk("entry_op_disp", disp, 7);
        chk("entry_op_sign", sign, 1);

        clr();
        push_num(200);
        push_num(100);
        op_idle(0);
        chk("add_disp", disp, 212);
        chk("add_sign", sign, 1);
        chk("add_ovf", ovf, 1);

        clr();
        key(2);
        key(5);
        key(6);
        chk("ent_ovf", ovf, 1);
        chk("ent_drop", disp, 25);

        clr();
        push_num(1);
        push_num(2);
        push_num(3);
        push_num(4);
        ent();
        chk("full_err", err, 1);
        chk("full_depth", depth, 4);
        chk("full_disp", disp, 4);
        clr();
        chk("clr_err", err, 0);
        push_num(7);
        op_idle(0);
        chk("under_err", err, 1);
        chk("under_rr", result_ready, 0);
        chk("under_depth", depth, 1);
        chk("under_disp", disp, 7);

        clr();
        push_num(12);
        push_num(10);
        op_idle(2);
        chk("and_disp", disp, 8);
        push_num(6);
        op_idle(3);
        chk("or_disp", disp, 14);
        push_num(7);
        op_idle(4);
        chk("xor_disp", disp, 9);
        op_idle(5);
        chk("neg_disp", disp, 9);
        chk("neg_sign", sign, 1);
        op_idle(7);
        chk("drop_depth", depth, 0);
        chk("drop_disp", disp, 0);
        chk("drop_err", err, 0);
        op_idle(5);
        chk("neg_empty_err", err, 1);

        clr();
        ent();
        chk("dup_empty_depth", depth, 1);
        chk("dup_empty_disp", disp, 0);
        push_num(5);
        ent();
        chk("dup_depth", depth, 3);
        chk("dup_disp", disp, 5);

        clr();
        push_num(255);
        op_idle(5);
        push_num(1);
        op_idle(1);
        chk("min_disp", disp, 256);
        chk("min_sign", sign, 1);
        chk("min_ovf", ovf, 0);
        op_idle(5);
        chk("negmin_ovf", ovf, 1);
        chk("negmin_disp", disp, 256);

        clr();
        push_num(3);
        key(4);
        op_vld = 1'b1;
        opcode = 3'd0;
        enter = 1'b1;
        digit_vld = 1'b1;
        digit = 4'd1;
        tick();
        op_vld = 1'b0;
        enter = 1'b0;
        digit_vld = 1'b0;
        tick();
        tick();
        chk("prio_depth", depth, 1);
        chk("prio_disp", disp, 7);

`ifdef RPN_CALC_MUL_EN
        clr();
        push_num(13);
        push_num(9);
        op_idle(5);
        op_vld = 1'b1;
        opcode = 3'd6;
        tick();
        op_vld = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        chk("mul_busy_cycles", n, 9);
        chk("mul_rr", result_ready, 1);
        chk("mul_disp", disp, 117);
        chk("mul_sign", sign, 1);
        chk("mul_ovf", ovf, 0);
        chk("mul_depth", depth, 1);

        clr();
        push_num(20);
        push_num(30);
        op_vld = 1'b1;
        opcode = 3'd6;
        tick();
        op_vld = 1'b0;
        tick();
        tick();
        chk("mul_mid_busy", busy, 1);
        clr();
        chk("abort_busy", busy, 0);
        chk("abort_depth", depth, 0);
        chk("abort_disp", disp, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_err", err, 0);
        chk("abort_rr", result_ready, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (result_ready) n++;
        end
        chk("abort_no_rr", n, 0);
`else
        clr();
        push_num(13);
        push_num(9);
        op_idle(6);
        chk("mul_ill_err", err, 1);
        chk("mul_ill_rr", result_ready, 0);
        chk("mul_ill_depth", depth, 2);
        chk("mul_ill_disp", disp, 9);
        key(4);
        clr();
        chk("clr_entry_disp", disp, 0);
        chk("clr_entry_err", err, 0);
        chk("clr_entry_depth", depth, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
